// File: rtl/weight_frame_pkg.sv
// Shared constants for the weight frame checker: FSM state codes, reply commands and
// the default frame delimiter.
package weight_frame_pkg;

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StRxMin  = 3'd1;
  localparam logic [2:0] StRxMax  = 3'd2;
  localparam logic [2:0] StRxMeas = 3'd3;
  localparam logic [2:0] StRxCsum = 3'd4;
  localparam logic [2:0] StCheck  = 3'd5;

  localparam logic [7:0] CmdNone   = 8'h00;
  localparam logic [7:0] CmdAccept = 8'h41;  // 'A'
  localparam logic [7:0] CmdReject = 8'h52;  // 'R'
  localparam logic [7:0] CmdError  = 8'h45;  // 'E'

  localparam logic [7:0] DefaultStartByte = 8'h23;  // '#'

endpackage

// File: rtl/interbyte_timeout.sv
// Inter-byte watchdog: counts idle cycles while enabled and flags expiry on the cycle whose
// count would reach TIMEOUT_CYCLES-1; a clear in that same cycle suppresses expiry.
module interbyte_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CntW-1:0] LastCnt = CntW'(TIMEOUT_CYCLES - 2);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != LastCnt)) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = en_i && !clr_i && (cnt_q == LastCnt);

endmodule

// File: rtl/weight_frame_checker.sv
// Assembles '#'-delimited {min, max, measured} weight frames from a UART byte stream and
// emits a one-cycle result strobe. Optional trailing XOR checksum byte: define CHECKSUM_EN.
module weight_frame_checker
  import weight_frame_pkg::*;
#(
  parameter int unsigned FIELD_BYTES    = 1,
  parameter logic [7:0]  START_BYTE     = DefaultStartByte,
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  localparam int unsigned W             = 8 * FIELD_BYTES
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         rx_valid,
  input  logic [7:0]   rx_byte,
  output logic         result_valid,
  output logic         peso_ok,
  output logic [W-1:0] peso_permitido,
  output logic         abaixo,
  output logic         acima,
  output logic         erro,
  output logic [7:0]   comando
);

  localparam int unsigned BcntW = (FIELD_BYTES > 1) ? $clog2(FIELD_BYTES) : 1;
  localparam logic [BcntW-1:0] LastByte = BcntW'(FIELD_BYTES - 1);

  logic [2:0]       state_q, state_d;
  logic [BcntW-1:0] bcnt_q, bcnt_d, bcnt_nxt;
  logic [W-1:0]     min_q, min_d, max_q, max_d, meas_q, meas_d;
  logic             result_valid_q, result_valid_d;
  logic             ok_q, ok_d, abaixo_q, abaixo_d, acima_q, acima_d, erro_q, erro_d;
  logic [W-1:0]     perm_q, perm_d;
  logic [7:0]       cmd_q, cmd_d;

  logic in_frame, last_byte, expired, abort, publish;
  logic chk_err, chk_below, chk_above, chk_ok;

  function automatic logic [W-1:0] shift_in(logic [W-1:0] field, logic [7:0] b);
    return (field << 8) | W'(b);
  endfunction

  assign in_frame  = state_q inside {StRxMin, StRxMax, StRxMeas, StRxCsum};
  assign last_byte = (bcnt_q == LastByte);
  assign bcnt_nxt  = last_byte ? '0 : bcnt_q + BcntW'(1);

  // Held clear outside a frame, so entering RX_MIN always starts from zero.
  interbyte_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clock),
    .rst_i    (reset),
    .clr_i    (!in_frame || rx_valid),
    .en_i     (in_frame),
    .expired_o(expired)
  );

`ifdef CHECKSUM_EN
  logic [7:0] xor_q, xor_d;
  logic       csum_bad_q, csum_bad_d;

  always_comb begin
    xor_d      = xor_q;
    csum_bad_d = csum_bad_q;
    if (state_q == StIdle) begin
      xor_d      = '0;
      csum_bad_d = 1'b0;
    end else if (rx_valid && (state_q inside {StRxMin, StRxMax, StRxMeas})) begin
      xor_d = xor_q ^ rx_byte;
    end else if (rx_valid && (state_q == StRxCsum)) begin
      csum_bad_d = (rx_byte != xor_q);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      xor_q      <= '0;
      csum_bad_q <= 1'b0;
    end else begin
      xor_q      <= xor_d;
      csum_bad_q <= csum_bad_d;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    min_d   = min_q;
    max_d   = max_q;
    meas_d  = meas_q;
    abort   = 1'b0;
    publish = 1'b0;
    case (state_q)
      StIdle: begin
        if (rx_valid && (rx_byte == START_BYTE)) begin
          state_d = StRxMin;
          bcnt_d  = '0;
          min_d   = '0;
          max_d   = '0;
          meas_d  = '0;
        end
      end
      StRxMin: begin
        if (rx_valid) begin
          min_d  = shift_in(min_q, rx_byte);
          bcnt_d = bcnt_nxt;
          if (last_byte) state_d = StRxMax;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StRxMax: begin
        if (rx_valid) begin
          max_d  = shift_in(max_q, rx_byte);
          bcnt_d = bcnt_nxt;
          if (last_byte) state_d = StRxMeas;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      StRxMeas: begin
        if (rx_valid) begin
          meas_d = shift_in(meas_q, rx_byte);
          bcnt_d = bcnt_nxt;
`ifdef CHECKSUM_EN
          if (last_byte) state_d = StRxCsum;
`else
          if (last_byte) state_d = StCheck;
`endif
        end else if (expired) begin
          abort = 1'b1;
        end
      end
`ifdef CHECKSUM_EN
      StRxCsum: begin
        if (rx_valid) begin
          state_d = StCheck;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
`endif
      StCheck: begin
        // Any byte arriving here is dropped.
        publish = 1'b1;
      end
      default: state_d = StIdle;
    endcase
    if (abort || publish) state_d = StIdle;
  end

  always_comb begin
    chk_err = (min_q > max_q);
`ifdef CHECKSUM_EN
    chk_err = chk_err || csum_bad_q;
`endif
    chk_below = !chk_err && (meas_q < min_q);
    chk_above = !chk_err && (meas_q > max_q);
    chk_ok    = !chk_err && !chk_below && !chk_above;
  end

  always_comb begin
    result_valid_d = abort || publish;
    ok_d           = ok_q;
    perm_d         = perm_q;
    abaixo_d       = abaixo_q;
    acima_d        = acima_q;
    erro_d         = erro_q;
    cmd_d          = cmd_q;
    if (abort || publish) begin
      erro_d   = abort || chk_err;
      ok_d     = !abort && chk_ok;
      abaixo_d = !abort && chk_below;
      acima_d  = !abort && chk_above;
      perm_d   = (!abort && chk_ok) ? meas_q : '0;
      if (abort || chk_err) begin
        cmd_d = CmdError;
      end else if (chk_ok) begin
        cmd_d = CmdAccept;
      end else begin
        cmd_d = CmdReject;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      bcnt_q         <= '0;
      min_q          <= '0;
      max_q          <= '0;
      meas_q         <= '0;
      result_valid_q <= 1'b0;
      ok_q           <= 1'b0;
      perm_q         <= '0;
      abaixo_q       <= 1'b0;
      acima_q        <= 1'b0;
      erro_q         <= 1'b0;
      cmd_q          <= CmdNone;
    end else begin
      state_q        <= state_d;
      bcnt_q         <= bcnt_d;
      min_q          <= min_d;
      max_q          <= max_d;
      meas_q         <= meas_d;
      result_valid_q <= result_valid_d;
      ok_q           <= ok_d;
      perm_q         <= perm_d;
      abaixo_q       <= abaixo_d;
      acima_q        <= acima_d;
      erro_q         <= erro_d;
      cmd_q          <= cmd_d;
    end
  end

  assign result_valid   = result_valid_q;
  assign peso_ok        = ok_q;
  assign peso_permitido = perm_q;
  assign abaixo         = abaixo_q;
  assign acima          = acima_q;
  assign erro           = erro_q;
  assign comando        = cmd_q;

endmodule
